// File: rtl/sha256_msg_padder_if.sv
// Handshake bundle between the byte-stream source, the SHA-256 padder and the
// SHA-256 core's block-load port.
// master: the padder. It consumes the byte stream and drives the core word writes.
// slave : the environment. It is the byte source plus the core.
interface sha256_msg_padder_if;
   // byte stream in
   logic [7:0]  s_data;
   logic        s_valid;
   logic        s_last;
   logic        s_ready;
   // core side
   logic        core_ready;
   logic        msg_init;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [31:0] wr_data;
   logic        blk_start;
   logic        msg_done;
   logic        busy;

   modport master (
      input  s_data, s_valid, s_last, core_ready,
      output s_ready, msg_init, wr_en, wr_addr, wr_data, blk_start, msg_done, busy
   );

   modport slave (
      output s_data, s_valid, s_last, core_ready,
      input  s_ready, msg_init, wr_en, wr_addr, wr_data, blk_start, msg_done, busy
   );
endinterface

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder.
// Bytes are packed little-endian into 32-bit words, with the first byte in [7:0].
// Each 512-bit block is written to the core as word indices 0..15, followed by blk_start.
// The padder appends PAD_BYTE and the zero fill, then the 64-bit message bit-length in words 14/15.
// A second block is added when the length does not fit.
// Optional build macro SHA_PAD_ABORT_EN adds an 'abort' input.
// That input drops the current message and returns the padder to IDLE without msg_done.
module sha256_msg_padder #(
   parameter logic [7:0]  PAD_BYTE = 8'h80,
   parameter int unsigned LEN_W    = 32
) (
   input  logic clk_in,
   input  logic rst_in,
`ifdef SHA_PAD_ABORT_EN
   input  logic abort,
`endif
   sha256_msg_padder_if.master bus
);

   typedef enum logic [3:0] {
      IDLE, INIT, FILL, PAD, ZERO, LEN_HI, LEN_LO, START, WAIT, DONE
   } state_t;

   state_t           state_q;
   logic [LEN_W-1:0] byte_cnt_q;   // accepted message bytes
   logic [3:0]       word_idx_q;   // next word index within the block
   logic [31:0]      acc_q;        // partially packed word
   logic             msg_open_q;   // block filled mid-message, more bytes follow
   logic             pad_pend_q;   // s_last closed a full block, pad word starts next block
   logic             pad2_q;       // pad landed in word 14/15, length goes in an extra block
   logic             hold_q;       // ignore core_ready while the core sees blk_start

   // registered outputs
   logic        s_ready_q;
   logic        msg_init_q;
   logic        wr_en_q;
   logic [3:0]  wr_addr_q;
   logic [31:0] wr_data_q;
   logic        blk_start_q;
   logic        msg_done_q;

   logic        abort_hit;
   logic [1:0]  lane;
   logic        accept;
   logic [31:0] acc_d;
   logic [31:0] pad_word_d;
   logic [63:0] bit_len;

`ifdef SHA_PAD_ABORT_EN
   assign abort_hit = abort;
`else
   assign abort_hit = 1'b0;
`endif

   assign lane    = byte_cnt_q[1:0];
   assign accept  = (state_q == FILL) && s_ready_q && bus.s_valid;
   assign bit_len = 64'({byte_cnt_q, 3'b000});

   // Merge the incoming byte or the pad byte into the current lane of the accumulator.
   always_comb begin
      // NOTE: every combinational output gets a full default first so no latch is inferred.
      acc_d      = acc_q;
      pad_word_d = acc_q;
      acc_d[{lane, 3'b000} +: 8]      = bus.s_data;
      pad_word_d[{lane, 3'b000} +: 8] = PAD_BYTE;
   end

   // Padding sequencer: state, counters, accumulator and all registered outputs.
   // NOTE: the reset is asynchronous and active-low, so it sits in the sensitivity list.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q     <= IDLE;
         byte_cnt_q  <= '0;
         word_idx_q  <= '0;
         acc_q       <= '0;
         msg_open_q  <= 1'b0;
         pad_pend_q  <= 1'b0;
         pad2_q      <= 1'b0;
         hold_q      <= 1'b0;
         s_ready_q   <= 1'b0;
         msg_init_q  <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         blk_start_q <= 1'b0;
         msg_done_q  <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only, so every register updates from pre-edge values.
         msg_init_q  <= 1'b0;
         wr_en_q     <= 1'b0;
         blk_start_q <= 1'b0;
         msg_done_q  <= 1'b0;

         case (state_q)
            IDLE: begin
               if (bus.s_valid && bus.core_ready) begin
                  state_q    <= INIT;
                  msg_init_q <= 1'b1;
               end
            end

            INIT: begin
               state_q   <= FILL;
               s_ready_q <= 1'b1;
            end

            FILL: begin
               if (accept) begin
                  byte_cnt_q <= byte_cnt_q + LEN_W'(1);
                  if (lane == 2'd3) begin
                     wr_en_q    <= 1'b1;
                     wr_addr_q  <= word_idx_q;
                     wr_data_q  <= acc_d;
                     acc_q      <= '0;
                     word_idx_q <= word_idx_q + 4'd1;
                  end else begin
                     acc_q <= acc_d;
                  end
                  if ((lane == 2'd3) && (word_idx_q == 4'd15)) begin
                     s_ready_q  <= 1'b0;
                     state_q    <= START;
                     msg_open_q <= !bus.s_last;
                     pad_pend_q <= bus.s_last;
                  end else if (bus.s_last) begin
                     s_ready_q <= 1'b0;
                     state_q   <= PAD;
                  end
               end
            end

            PAD: begin
               wr_en_q    <= 1'b1;
               wr_addr_q  <= word_idx_q;
               wr_data_q  <= pad_word_d;
               acc_q      <= '0;
               word_idx_q <= word_idx_q + 4'd1;
               if (word_idx_q == 4'd15) begin
                  state_q <= START;
                  pad2_q  <= 1'b1;
               end else if (word_idx_q == 4'd13) begin
                  state_q <= LEN_HI;
               end else begin
                  state_q <= ZERO;
                  pad2_q  <= (word_idx_q == 4'd14);
               end
            end

            ZERO: begin
               wr_en_q    <= 1'b1;
               wr_addr_q  <= word_idx_q;
               wr_data_q  <= '0;
               word_idx_q <= word_idx_q + 4'd1;
               if (pad2_q && (word_idx_q == 4'd15)) begin
                  state_q <= START;
               end else if (!pad2_q && (word_idx_q == 4'd13)) begin
                  state_q <= LEN_HI;
               end
            end

            LEN_HI: begin
               wr_en_q    <= 1'b1;
               wr_addr_q  <= word_idx_q;
               wr_data_q  <= bit_len[63:32];
               word_idx_q <= word_idx_q + 4'd1;
               state_q    <= LEN_LO;
            end

            LEN_LO: begin
               wr_en_q    <= 1'b1;
               wr_addr_q  <= word_idx_q;
               wr_data_q  <= bit_len[31:0];
               word_idx_q <= word_idx_q + 4'd1;
               state_q    <= START;
            end

            START: begin
               blk_start_q <= 1'b1;
               hold_q      <= 1'b1;
               state_q     <= WAIT;
            end

            WAIT: begin
               if (hold_q) begin
                  hold_q <= 1'b0;
               end else if (bus.core_ready) begin
                  if (msg_open_q) begin
                     msg_open_q <= 1'b0;
                     s_ready_q  <= 1'b1;
                     state_q    <= FILL;
                  end else if (pad_pend_q) begin
                     pad_pend_q <= 1'b0;
                     state_q    <= PAD;
                  end else if (pad2_q) begin
                     pad2_q  <= 1'b0;
                     state_q <= ZERO;
                  end else begin
                     msg_done_q <= 1'b1;
                     state_q    <= DONE;
                  end
               end
            end

            DONE: begin
               byte_cnt_q <= '0;
               word_idx_q <= '0;
               acc_q      <= '0;
               state_q    <= IDLE;
            end

            default: state_q <= IDLE;
         endcase

         // Abort overrides whatever the case above scheduled.
         if (abort_hit) begin
            state_q     <= IDLE;
            byte_cnt_q  <= '0;
            word_idx_q  <= '0;
            acc_q       <= '0;
            msg_open_q  <= 1'b0;
            pad_pend_q  <= 1'b0;
            pad2_q      <= 1'b0;
            hold_q      <= 1'b0;
            s_ready_q   <= 1'b0;
            msg_init_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            blk_start_q <= 1'b0;
            msg_done_q  <= 1'b0;
         end
      end
   end

   assign bus.s_ready   = s_ready_q;
   assign bus.msg_init  = msg_init_q;
   assign bus.wr_en     = wr_en_q;
   assign bus.wr_addr   = wr_addr_q;
   assign bus.wr_data   = wr_data_q;
   assign bus.blk_start = blk_start_q;
   assign bus.msg_done  = msg_done_q;
   assign bus.busy      = (state_q != IDLE);

endmodule

// File: doc/sha256_msg_padder.md
Name: sha256_msg_padder

Overview:
- Upstream feeder for the SHA-256 core: accepts a raw message as a byte stream and performs SHA-256 padding (pad byte, zero fill, 64-bit bit-length).
- Emits each padded 512-bit block to the core as 16 addressed word writes followed by a start pulse.
- Sequences multi-block messages: waits for the core to go idle before each new block, and signals message init and completion.

Parameters:
- PAD_BYTE, 8'h80, marker byte appended directly after the last message byte.
- LEN_W, 32, width of the internal message byte counter; maximum message length is 2^LEN_W-1 bytes.

Ports:
- clk_in  in  1  system clock, all logic on rising edge
- rst_in  in  1  asynchronous active-low reset
- s_data  in  8  message byte
- s_valid  in  1  s_data valid
- s_last  in  1  qualifies the final byte of the message
- s_ready  out  1  byte accepted when s_valid&s_ready
- core_ready  in  1  core idle and able to take a new block or init
- msg_init  out  1  one-cycle pulse: core reloads initial hash H0..H7
- wr_en  out  1  one-cycle word write strobe
- wr_addr  out  4  word index 0..15 within the block
- wr_data  out  32  word data
- blk_start  out  1  one-cycle pulse: block complete, core starts compression
- msg_done  out  1  one-cycle pulse after the final blk_start
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: all outputs 0, FSM=IDLE, byte counter=0, word index=0, accumulator=0. Reset mid-message discards all partial state; no further writes or pulses are issued.
- Byte packing: the first byte of each word goes to bits[7:0], the fourth byte to bits[31:24].
- Word indices 0..15 are written in strict ascending order per block.
- States: IDLE, INIT, FILL, PAD, ZERO, LEN_HI, LEN_LO, START, WAIT, DONE.
- IDLE: s_ready=0. When s_valid=1 and core_ready=1, go to INIT.
- INIT: msg_init=1 for one cycle, then go to FILL.
- FILL:
  - s_ready=1; throughput is 1 byte/cycle.
  - Each accepted byte increments the byte counter.
  - On the 4th byte of a word, wr_en/wr_addr/wr_data are registered and appear the cycle after acceptance.
  - On accepting s_last, go to PAD.
  - If an accepted byte completes word 15, s_ready drops the next cycle and the FSM goes to START.
- PAD: PAD_BYTE is placed in the next free byte lane. The remaining lanes of that word are zero. The word is written.
- ZERO:
  - Writes zero words until the word index reaches 14, then goes to LEN_HI.
  - If the pad word landed at index 14 or 15: zero-fill to 15, START, WAIT, then a new block of zeros 0..13, then LEN_HI.
- LEN_HI: writes word 14 = upper 32 bits of (byte_count*8) as a 64-bit value.
- LEN_LO: writes word 15 = lower 32 bits of that value. Then START.
- START: blk_start=1 for one cycle, on the cycle after the word-15 write.
- WAIT:
  - The core deasserts core_ready in the cycle after blk_start; the padder ignores core_ready during that cycle.
  - The FSM then waits for core_ready=1.
  - Next state is FILL if the message is still open, ZERO if the second padding block is pending, otherwise DONE.
- DONE: msg_done=1 for one cycle, counter cleared, return to IDLE.
- Boundaries (byte counts):
  - A message with 4k bytes gets the pad byte at byte 0 of a new word.
  - 55 bytes: single block.
  - 56..63 bytes: two blocks.
  - 64 bytes: the pad word starts block 2.
- Zero-length messages are unsupported; s_last must accompany a data byte.
- Counter overflow beyond 2^LEN_W-1 bytes wraps silently.

Optional Feature:
- SHA_PAD_ABORT_EN:
  - Defined: adds input port abort (1 bit). When abort=1 in any state, the FSM returns to IDLE next cycle and clears the counter, index and accumulator. A blk_start already issued is not revoked. No msg_done is issued. abort takes priority over s_valid in the same cycle.
  - Undefined: no abort port; messages run to msg_done or reset only.

Test Plan:
- "abc" (61,62,63, s_last on 63), core_ready=1:
  - msg_init once.
  - word0=0x80636261, words1..14=0, word15=0x00000018.
  - one blk_start, then msg_done.
- 55 bytes of 0x00: single block, word13=0x80000000, word15=0x000001B8, one blk_start.
- 56 bytes of 0x00:
  - block1 word14=0x00000080, word15=0, blk_start.
  - block2 words0..14=0, word15=0x000001C0.
  - two blk_start, msg_done after the second.
- 64 bytes, core_ready held low 10 cycles after the first blk_start:
  - s_ready=0 and no wr_en during the stall.
  - block2 word0=0x00000080, word15=0x00000200.
- Assert rst_in=0 after 20 bytes accepted: all outputs 0 next edge. A fresh "abc" afterwards reproduces test 1 exactly.
- With SHA_PAD_ABORT_EN: abort after 10 bytes gives IDLE next cycle and no msg_done. A following "abc" reproduces test 1 exactly.
